// File: rtl/mem_port_arbiter.sv
// Shares the data-memory stage between the core MEM stage (port C) and the key loader (port L).
// Fixed priority with loader starvation relief and burst lock; read data and range errors return after READ_LATENCY.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int READ_LATENCY = 1,
    parameter int MAX_WAIT     = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_req,
    input  logic             c_we,
    input  logic [WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0] c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [WIDTH-1:0] c_rdata,
    output logic             c_err,
    input  logic             l_req,
    input  logic             l_we,
    input  logic [WIDTH-1:0] l_addr,
    input  logic [WIDTH-1:0] l_wdata,
    input  logic             l_lock,
    output logic             l_gnt,
    output logic             l_rvalid,
    output logic [WIDTH-1:0] l_rdata,
    output logic             l_err,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef struct packed {
        logic valid;
        logic port;     // 1 = loader
        logic is_read;
        logic err;
    } tag_t;

    logic [WW-1:0]    wait_cnt_reg;
    logic [BW-1:0]    burst_cnt_reg;
    logic             l_last_reg;
    tag_t             tag_reg [READ_LATENCY];
    logic [WIDTH-1:0] c_rdata_reg;
    logic [WIDTH-1:0] l_rdata_reg;

    logic             starved;
    logic             lock_hold;
    logic             grant_c;
    logic             grant_l;
    logic             any_gnt;
    logic             win_we;
    logic [WIDTH-1:0] win_addr;
    logic [WIDTH-1:0] win_wdata;
    logic             in_range;
    tag_t             new_tag;
    tag_t             out_tag;
    logic             c_hit;
    logic             l_hit;
    logic [WIDTH-1:0] c_rdata_next;
    logic [WIDTH-1:0] l_rdata_next;

    always_comb begin
        starved   = l_req && (wait_cnt_reg == WW'(MAX_WAIT));
        lock_hold = l_last_reg && l_lock && l_req && (burst_cnt_reg < BW'(MAX_BURST));
        grant_c   = 1'b0;
        grant_l   = 1'b0;
        if (!rst) begin
            if (lock_hold || starved) begin
                grant_l = 1'b1;
            end else if (c_req) begin
                grant_c = 1'b1;
            end else if (l_req) begin
                grant_l = 1'b1;
            end
        end
    end

    assign any_gnt   = grant_c || grant_l;
    assign win_we    = grant_l ? l_we    : c_we;
    assign win_addr  = grant_l ? l_addr  : c_addr;
    assign win_wdata = grant_l ? l_wdata : c_wdata;
    assign in_range  = ((win_addr >> 18) == '0);

    assign c_gnt     = grant_c;
    assign l_gnt     = grant_l;
    assign mem_we    = any_gnt && win_we && in_range;
    assign mem_addr  = any_gnt ? win_addr  : '0;
    assign mem_wdata = any_gnt ? win_wdata : '0;

    always_comb begin
        new_tag         = '0;
        new_tag.valid   = any_gnt;
        new_tag.port    = grant_l;
        new_tag.is_read = any_gnt && !win_we;
        new_tag.err     = any_gnt && !in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg  <= '0;
            burst_cnt_reg <= '0;
            l_last_reg    <= 1'b0;
        end else begin
            if (l_req && !grant_l) begin
                wait_cnt_reg <= (wait_cnt_reg == WW'(MAX_WAIT)) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
            end else begin
                wait_cnt_reg <= '0;
            end
            // Counts locked loader grants including the first; any lost grant or dropped lock restarts it.
            if (grant_l && l_lock) begin
                burst_cnt_reg <= (burst_cnt_reg == BW'(MAX_BURST)) ? burst_cnt_reg : burst_cnt_reg + 1'b1;
            end else begin
                burst_cnt_reg <= '0;
            end
            l_last_reg <= grant_l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    // The tag leaves the pipe in the same cycle the memory presents the read data.
    assign out_tag  = tag_reg[READ_LATENCY-1];
    assign c_hit    = !rst && out_tag.valid && !out_tag.port;
    assign l_hit    = !rst && out_tag.valid && out_tag.port;
    assign c_rvalid = c_hit && out_tag.is_read;
    assign l_rvalid = l_hit && out_tag.is_read;
    assign c_err    = c_hit && out_tag.err;
    assign l_err    = l_hit && out_tag.err;

    always_comb begin
        c_rdata_next = c_rdata_reg;
        l_rdata_next = l_rdata_reg;
        if (c_rvalid) begin
            c_rdata_next = out_tag.err ? '0 : mem_rdata;
        end
        if (l_rvalid) begin
            l_rdata_next = out_tag.err ? '0 : mem_rdata;
        end
    end

    assign c_rdata = rst ? '0 : c_rdata_next;
    assign l_rdata = rst ? '0 : l_rdata_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            c_rdata_reg <= '0;
            l_rdata_reg <= '0;
        end else begin
            c_rdata_reg <= c_rdata_next;
            l_rdata_reg <= l_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural memory stage, per-cycle reference model and directed scenarios.
module tb_mem_port_arbiter;

    localparam int RL = 1;
    localparam int MW = 4;
    localparam int MB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic        c_gnt, c_rvalid, c_err, l_gnt, l_rvalid, l_err, mem_we;
    logic [31:0] c_rdata, l_rdata, mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.WIDTH(32), .READ_LATENCY(RL), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stage: write-first, READ_LATENCY cycles of read delay.
    logic [31:0] mem_arr [0:65535];
    logic [31:0] rd_pipe [RL];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr[17:2]] <= mem_wdata;
        rd_pipe[0] <= mem_we ? mem_wdata : mem_arr[mem_addr[17:2]];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: grant rules, a word-addressed memory image and responses keyed by due cycle.
    typedef struct {
        logic        port;
        logic        rd;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       pend [int];
    logic [31:0] ref_mem [int];
    int          cyc = 0;
    int          m_wait = 0, m_burst = 0;
    logic        m_lprev = 1'b0;
    logic [31:0] m_c_rdata = '0, m_l_rdata = '0;

    always @(negedge clk) begin : model
        logic        ec_gnt, el_gnt, e_we, ec_rv, el_rv, ec_err, el_err;
        logic [31:0] e_addr, e_wdata, a, d;
        resp_t       r;
        ec_gnt = 0; el_gnt = 0; e_we = 0; ec_rv = 0; el_rv = 0; ec_err = 0; el_err = 0;
        e_addr = '0; e_wdata = '0;
        if (rst) begin
            m_wait = 0; m_burst = 0; m_lprev = 0;
            m_c_rdata = '0; m_l_rdata = '0;
            pend.delete();
        end else begin
            if (l_req && ((m_lprev && l_lock && m_burst < MB) || m_wait == MW)) el_gnt = 1;
            else if (c_req) ec_gnt = 1;
            else if (l_req) el_gnt = 1;
            if (ec_gnt || el_gnt) begin
                a = el_gnt ? l_addr : c_addr;
                d = el_gnt ? l_wdata : c_wdata;
                r.port = el_gnt;
                r.rd   = el_gnt ? !l_we : !c_we;
                r.err  = (a >= 32'h40000);
                r.data = (r.err || !ref_mem.exists(int'(a[17:2]))) ? 32'h0 : ref_mem[int'(a[17:2])];
                if (!r.rd && !r.err) ref_mem[int'(a[17:2])] = d;
                e_we = !r.rd && !r.err;
                e_addr = a;
                e_wdata = d;
                pend[cyc + RL] = r;
            end
            if (pend.exists(cyc)) begin
                r = pend[cyc];
                pend.delete(cyc);
                if (r.port) begin
                    el_rv = r.rd; el_err = r.err;
                    if (r.rd) m_l_rdata = r.data;
                end else begin
                    ec_rv = r.rd; ec_err = r.err;
                    if (r.rd) m_c_rdata = r.data;
                end
            end
            m_wait  = (l_req && !el_gnt) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
            m_burst = (el_gnt && l_lock) ? ((m_burst < MB) ? m_burst + 1 : MB) : 0;
            m_lprev = el_gnt;
        end
        check("cmp_c_gnt", c_gnt, ec_gnt);
        check("cmp_l_gnt", l_gnt, el_gnt);
        check("cmp_mem_we", mem_we, e_we);
        check("cmp_mem_addr", mem_addr, e_addr);
        check("cmp_mem_wdata", mem_wdata, e_wdata);
        check("cmp_c_rvalid", c_rvalid, ec_rv);
        check("cmp_l_rvalid", l_rvalid, el_rv);
        check("cmp_c_err", c_err, ec_err);
        check("cmp_l_err", l_err, el_err);
        check("cmp_c_rdata", c_rdata, m_c_rdata);
        check("cmp_l_rdata", l_rdata, m_l_rdata);
        cyc++;
    end

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                         input logic lk);
        @(posedge clk);
        #1;
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic core_read_check(input string name, input logic [31:0] a, input logic [31:0] e);
        drive(1, 0, a, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check({name, "_gnt"}, c_gnt, 1);
        for (int k = 1; k <= RL; k++) idle_cycle();
        check({name, "_rvalid"}, c_rvalid, 1);
        check({name, "_rdata"}, c_rdata, e);
    endtask

    initial begin : stim
        int   b;
        int   k;
        logic cdone;

        repeat (3) begin
            @(negedge clk);
            check("rst_c_gnt", c_gnt, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_c_rdata", c_rdata, 0);
        end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);

        // Write then read back on the following cycle.
        drive(1, 1, 32'h10000, 32'h10024, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_wr_gnt", c_gnt, 1);
        check("t1_wr_we", mem_we, 1);
        check("t1_wr_addr", mem_addr, 32'h10000);
        drive(1, 0, 32'h10000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t1_rd_gnt", c_gnt, 1);
        check("t1_rd_we", mem_we, 0);
        for (int i = 1; i <= RL + 1; i++) begin
            idle_cycle();
            check("t1_rvalid", c_rvalid, (i == RL));
            if (i == RL) check("t1_rdata", c_rdata, 32'h10024);
        end

        // Contention: loader starves after MAX_WAIT denials.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 32'h100, 32'hC0 + i, 1, 1, 32'h104, 32'hD0 + i, 0);
            @(negedge clk);
            check("t2_c_gnt", c_gnt, (i != 4));
            check("t2_l_gnt", l_gnt, (i == 4));
        end
        repeat (3) idle_cycle();

        drive(1, 1, 32'h0, 32'h10, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 1, 32'h30004, 32'h30018, 0);
        @(negedge clk);
        check("prep_l_gnt", l_gnt, 1);
        repeat (2) idle_cycle();

        // Locked loader burst with a core request arriving at beat 2.
        b = 0; k = 0; cdone = 0;
        while (b < 16 && k < 40) begin
            drive(k >= 2 && !cdone, 0, 32'h10000, 0, 1, 1, 32'h20000 + 4 * b, 32'hA0000000 + b, 1);
            @(negedge clk);
            if (k < 8) check("t3_l_hold", l_gnt, 1);
            else if (k == 8) check("t3_c_slot", c_gnt, 1);
            else check("t3_l_resume", l_gnt, 1);
            if (l_gnt) b++;
            if (c_gnt) cdone = 1;
            k++;
        end
        check("t3_beats", b, 16);
        check("t3_cycles", k, 17);
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 32'h20000 + 4 * i, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        repeat (RL + 1) idle_cycle();
        core_read_check("t3_last", 32'h2003C, 32'hA000000F);
        core_read_check("t3_first", 32'h20000, 32'hA0000000);

        // Out-of-range read and write.
        drive(1, 0, 32'h40000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t4_rd_gnt", c_gnt, 1);
        check("t4_rd_we", mem_we, 0);
        for (int i = 1; i <= RL; i++) idle_cycle();
        check("t4_rd_rvalid", c_rvalid, 1);
        check("t4_rd_err", c_err, 1);
        check("t4_rd_rdata", c_rdata, 0);
        drive(1, 1, 32'h40000, 32'hDEAD, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("t4_wr_we", mem_we, 0);
        for (int i = 1; i <= RL; i++) idle_cycle();
        check("t4_wr_err", c_err, 1);
        check("t4_wr_rvalid", c_rvalid, 0);
        core_read_check("t4_bank", 32'h0, 32'h10);

        // Interleaved reads to both ports on consecutive cycles.
        for (int i = 0; i <= RL + 2; i++) begin
            if (i == 0) drive(1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
            else if (i == 1) drive(0, 0, 0, 0, 1, 0, 32'h30004, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check("t5_c_rvalid", c_rvalid, (i == RL));
            check("t5_l_rvalid", l_rvalid, (i == RL + 1));
            if (i == RL) check("t5_c_rdata", c_rdata, 32'h10);
            if (i == RL + 1) check("t5_l_rdata", l_rdata, 32'h30018);
        end

        // Burst saturates without core traffic; core then wins at once.
        for (int i = 0; i <= 10; i++) begin
            drive(i == 10, 0, 32'h0, 0, 1, 1, 32'h20100 + 4 * i, 32'hB0 + i, 1);
            @(negedge clk);
            check("t7_l_gnt", l_gnt, (i < 10));
            check("t7_c_gnt", c_gnt, (i == 10));
        end
        repeat (2) idle_cycle();

        // Reset right after a loader read grant discards the response.
        drive(0, 0, 0, 0, 1, 0, 32'h30004, 0, 0);
        @(negedge clk);
        check("t6_l_gnt", l_gnt, 1);
        @(posedge clk);
        #1;
        rst = 1;
        c_req = 1;
        l_req = 0;
        @(negedge clk);
        check("t6_rst_l_rvalid", l_rvalid, 0);
        check("t6_rst_c_gnt", c_gnt, 0);
        check("t6_rst_mem_addr", mem_addr, 0);
        check("t6_rst_l_rdata", l_rdata, 0);
        @(posedge clk);
        #1;
        rst = 0;
        c_req = 0;
        @(negedge clk);
        for (int i = 0; i < RL + 2; i++) begin
            idle_cycle();
            check("t6_post_l_rvalid", l_rvalid, 0);
            check("t6_post_l_err", l_err, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
